// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM states,
// requester indices and the read-latency counter helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    localparam int LAT_CNT_W = 2;

    // WAIT counts down to zero, so a latency of N loads N-1.
    function automatic logic [LAT_CNT_W-1:0] lat_cnt_init(input int read_latency);
        return LAT_CNT_W'(read_latency - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin winner select: on a tie the requester
// that did not own the previous transaction wins.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o  = req0_i | req1_i;
    assign winner_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the core (0)
// and the loader/debug host (1); one strobe per transaction, registered outputs.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int MEM_WIDTH    = 32,
    parameter  int MEM_SIZE     = 256,
    parameter  int READ_LATENCY = 1,
    localparam int AW           = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [AW-1:0]        m0_addr,
    input  logic [MEM_WIDTH-1:0] m0_wdata,
    output logic                 m0_ack,
    output logic [MEM_WIDTH-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [AW-1:0]        m1_addr,
    input  logic [MEM_WIDTH-1:0] m1_wdata,
    output logic                 m1_ack,
    output logic [MEM_WIDTH-1:0] m1_rdata,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val,
    output logic                 busy,
    output logic                 grant
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_cnt_init(READ_LATENCY);

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic                   we_q, we_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0]   mem_wval_q, mem_wval_d;
    logic                   mem_re_q, mem_re_d;
    logic                   mem_we_q, mem_we_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [MEM_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [MEM_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic                   busy_q, busy_d;

    logic                   pick_valid;
    logic                   pick_winner;
    logic                   sel_we;
    logic [AW-1:0]          sel_addr;
    logic [MEM_WIDTH-1:0]   sel_wdata;

    rr_pick2 u_pick (
        .req0_i       (m0_req),
        .req1_i       (m1_req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign sel_we    = (pick_winner == REQ_HOST) ? m1_we    : m0_we;
    assign sel_addr  = (pick_winner == REQ_HOST) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick_winner == REQ_HOST) ? m1_wdata : m0_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wval_d   = mem_wval_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            ST_IDLE: begin
                // Strobes are set here so they are registered during ACCESS.
                if (pick_valid) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    we_d         = sel_we;
                    mem_addr_d   = sel_addr;
                    mem_wval_d   = sel_wdata;
                    mem_we_d     = sel_we;
                    mem_re_d     = ~sel_we;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    ack0_d  = (grant_q == REQ_CORE);
                    ack1_d  = (grant_q == REQ_HOST);
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (grant_q == REQ_HOST) begin
                        rdata1_d = mem_read_val;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = mem_read_val;
                        ack0_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_HOST;
            grant_q      <= REQ_CORE;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wval_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wval_q   <= mem_wval_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign m0_ack        = ack0_q;
    assign m1_ack        = ack1_q;
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign mem_addr      = mem_addr_q;
    assign mem_read_en   = mem_re_q;
    assign mem_write_en  = mem_we_q;
    assign mem_write_val = mem_wval_q;
    assign busy          = busy_q;
    assign grant         = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at READ_LATENCY=1 for most
// scenarios and a second at READ_LATENCY=3 for the latency check.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance (READ_LATENCY = 1)
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [7:0]  mem_addr;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_write_val, mem_read_val;
    logic        busy, grant;

    // Second instance (READ_LATENCY = 3)
    logic        d3_m0_req, d3_m0_we, d3_m1_req, d3_m1_we;
    logic [7:0]  d3_m0_addr, d3_m1_addr;
    logic [31:0] d3_m0_wdata, d3_m1_wdata;
    logic        d3_m0_ack, d3_m1_ack;
    logic [31:0] d3_m0_rdata, d3_m1_rdata;
    logic [7:0]  d3_mem_addr;
    logic        d3_mem_read_en, d3_mem_write_en;
    logic [31:0] d3_mem_write_val, d3_mem_read_val;
    logic        d3_busy, d3_grant;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
        .busy(busy), .grant(grant)
    );

    mem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata),
        .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata),
        .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .mem_addr(d3_mem_addr), .mem_read_en(d3_mem_read_en), .mem_write_en(d3_mem_write_en),
        .mem_write_val(d3_mem_write_val), .mem_read_val(d3_mem_read_val),
        .busy(d3_busy), .grant(d3_grant)
    );

    // Memory model: word 8'h20 is preloaded; read data is valid only in the
    // exact cycle READ_LATENCY after the strobe, garbage otherwise.
    logic [31:0] tb_mem [256];
    logic [31:0] p1, p2, p3;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return (a == 8'h20) ? 32'h12345678 : tb_mem[a];
    endfunction

    always @(posedge clk) begin
        if (mem_write_en) tb_mem[mem_addr] <= mem_write_val;
        mem_read_val <= mem_read_en ? mem_word(mem_addr) : 32'hBADBAD00;
        p1 <= d3_mem_read_en ? mem_word(d3_mem_addr) : 32'hBADBAD00;
        p2 <= p1;
        p3 <= p2;
    end
    assign d3_mem_read_val = p3;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("chk %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0cnt;
        int a1cnt;
        logic exp_g;

        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 32'hDEADBEEF;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 32'h0;
        d3_m0_req = 1'b0; d3_m0_we = 1'b0; d3_m0_addr = 8'h00; d3_m0_wdata = 32'h0;
        d3_m1_req = 1'b0; d3_m1_we = 1'b0; d3_m1_addr = 8'h00; d3_m1_wdata = 32'h0;

        // Reset held with m0 requesting: nothing happens
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_we", 32'(mem_write_en), 32'd0);
            check("rst_re", 32'(mem_read_en), 32'd0);
            check("rst_ack0", 32'(m0_ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wval", mem_write_val, 32'h0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_rdata0", m0_rdata, 32'h0);
        check("rst_rdata1", m1_rdata, 32'h0);
        check("rst_d3_busy", 32'(d3_busy), 32'd0);

        // Release: m0 write 8'h10 <= DEADBEEF
        reset = 1'b1;
        step();
        check("wr_we", 32'(mem_write_en), 32'd1);
        check("wr_re", 32'(mem_read_en), 32'd0);
        check("wr_addr", 32'(mem_addr), 32'h10);
        check("wr_wval", mem_write_val, 32'hDEADBEEF);
        check("wr_grant", 32'(grant), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ack_early", 32'(m0_ack), 32'd0);
        step();
        check("wr_we_once", 32'(mem_write_en), 32'd0);
        check("wr_ack", 32'(m0_ack), 32'd1);
        check("wr_rdata0", m0_rdata, 32'h0);
        m0_req = 1'b0;
        step();
        check("wr_ack_pulse", 32'(m0_ack), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);
        check("wr_mem", tb_mem[8'h10], 32'hDEADBEEF);

        // m0 reads back 8'h10
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        step();
        check("rb_re", 32'(mem_read_en), 32'd1);
        check("rb_addr", 32'(mem_addr), 32'h10);
        step();
        check("rb_ack_early", 32'(m0_ack), 32'd0);
        step();
        check("rb_ack", 32'(m0_ack), 32'd1);
        check("rb_rdata0", m0_rdata, 32'hDEADBEEF);
        m0_req = 1'b0;
        step();

        // m1 read of 8'h20, READ_LATENCY=1: ack at cycle 3
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h20;
        step();
        check("r1_re", 32'(mem_read_en), 32'd1);
        check("r1_we", 32'(mem_write_en), 32'd0);
        check("r1_addr", 32'(mem_addr), 32'h20);
        check("r1_grant", 32'(grant), 32'd1);
        step();
        check("r1_re_once", 32'(mem_read_en), 32'd0);
        check("r1_ack_early", 32'(m1_ack), 32'd0);
        step();
        check("r1_ack", 32'(m1_ack), 32'd1);
        check("r1_rdata1", m1_rdata, 32'h12345678);
        check("r1_rdata0_kept", m0_rdata, 32'hDEADBEEF);
        m1_req = 1'b0;
        step();
        check("r1_ack_pulse", 32'(m1_ack), 32'd0);
        check("r1_idle", 32'(busy), 32'd0);

        // Same read on the READ_LATENCY=3 instance: ack at cycle 5
        d3_m1_req = 1'b1; d3_m1_addr = 8'h20;
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("rl3_ack_c%0d", c), 32'(d3_m1_ack), 32'(c == 5));
            if (c == 1) check("rl3_re", 32'(d3_mem_read_en), 32'd1);
            if (c == 5) check("rl3_rdata", d3_m1_rdata, 32'h12345678);
        end
        d3_m1_req = 1'b0;
        step();

        // Contention: both write continuously; grants must go 0,1,0,1
        m0_we = 1'b1; m0_addr = 8'h30; m0_wdata = 32'h11111111;
        m1_we = 1'b1; m1_addr = 8'h31; m1_wdata = 32'h22222222;
        m0_req = 1'b1; m1_req = 1'b1;
        a0cnt = 0; a1cnt = 0; exp_g = 1'b0;
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            do begin
                step();
                check("ct_strobe_excl", 32'(mem_read_en & mem_write_en), 32'd0);
                n++;
            end while (!(m0_ack | m1_ack) && n < 12);
            check("ct_ack_seen", 32'(m0_ack | m1_ack), 32'd1);
            check($sformatf("ct_grant_t%0d", t), 32'(grant), 32'(exp_g));
            check($sformatf("ct_ack1_t%0d", t), 32'(m1_ack), 32'(exp_g));
            if (m0_ack) a0cnt++;
            if (m1_ack) a1cnt++;
            if (t == 3) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end else if (m0_ack) begin
                m0_req = 1'b0;
            end else begin
                m1_req = 1'b0;
            end
            step();
            check("ct_strobe_excl", 32'(mem_read_en & mem_write_en), 32'd0);
            if (t < 3) begin
                m0_req = 1'b1; m1_req = 1'b1;
            end
            exp_g = ~exp_g;
        end
        check("ct_acks0", 32'(a0cnt), 32'd2);
        check("ct_acks1", 32'(a1cnt), 32'd2);
        check("ct_mem30", tb_mem[8'h30], 32'h11111111);
        check("ct_mem31", tb_mem[8'h31], 32'h22222222);
        step();
        check("ct_idle", 32'(busy), 32'd0);

        // Reset during WAIT of an m1 read: dropped, no ack
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h10;
        step();
        step();
        check("mo_busy_wait", 32'(busy), 32'd1);
        reset = 1'b0; m1_req = 1'b0;
        step();
        check("mo_busy", 32'(busy), 32'd0);
        check("mo_ack", 32'(m1_ack), 32'd0);
        check("mo_rdata1", m1_rdata, 32'h0);
        check("mo_rdata0", m0_rdata, 32'h0);
        check("mo_grant", 32'(grant), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mo_no_ack", 32'(m1_ack), 32'd0);
            check("mo_no_busy", 32'(busy), 32'd0);
        end

        // Violation: m0 drops req and changes addr during ACCESS
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20;
        step();
        check("vi_re", 32'(mem_read_en), 32'd1);
        check("vi_addr", 32'(mem_addr), 32'h20);
        m0_req = 1'b0; m0_addr = 8'h55;
        step();
        check("vi_addr_hold", 32'(mem_addr), 32'h20);
        check("vi_ack_early", 32'(m0_ack), 32'd0);
        step();
        check("vi_ack", 32'(m0_ack), 32'd1);
        check("vi_rdata0", m0_rdata, 32'h12345678);
        step();
        check("vi_ack_pulse", 32'(m0_ack), 32'd0);
        check("vi_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester round-robin arbiter that shares the core's single-ported instruction/data memory between requester 0 (core load/store and fetch path) and requester 1 (program loader / debug host).
- Each requester uses a req/ack handshake.
- The arbiter serialises accesses and drives the memory-side enables for exactly one cycle per transaction.
- It waits a parameterised read latency, then returns registered read data.
- It sits between the core's memory port and the memory array, at the same level as the core.

Parameters:
MEM_WIDTH, 32, data word width in bits
MEM_SIZE, 256, number of memory words; address width AW = $clog2(MEM_SIZE)
READ_LATENCY, 1, cycles from mem_read_en to valid mem_read_val; legal range 1..4

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset asserted), sampled on clk
m0_req  in  1  requester 0 access request, held until m0_ack
m0_we  in  1  requester 0: 1 = write, 0 = read
m0_addr  in  AW  requester 0 word address
m0_wdata  in  MEM_WIDTH  requester 0 write data
m0_ack  out  1  one-cycle completion pulse to requester 0
m0_rdata  out  MEM_WIDTH  requester 0 read data, valid with m0_ack, held until next read completes
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, for requester 1
mem_addr  out  AW  memory address
mem_read_en  out  1  memory read strobe
mem_write_en  out  1  memory write strobe
mem_write_val  out  MEM_WIDTH  memory write data
mem_read_val  in  MEM_WIDTH  memory read data
busy  out  1  1 whenever state != IDLE
grant  out  1  index of the requester owning the current or last transaction

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE
  - mem_addr = 0, mem_read_en = 0, mem_write_en = 0, mem_write_val = 0
  - m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0
  - busy = 0, grant = 0
  - internal last_grant = 1, so requester 0 wins the first tie.
- States (2-bit): IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - req signals are sampled only in IDLE.
  - Only one req high: that requester wins.
  - Both high: the requester != last_grant wins.
  - On a win: latch addr/we/wdata into mem_addr/mem_write_val and an internal we register; set grant and last_grant; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_read_en = !we, mem_write_en = we. Both are 0 in every other state.
  - Next state: DONE if write; WAIT with counter = READ_LATENCY - 1 if read.
- WAIT:
  - Counter nonzero: decrement and stay.
  - Counter zero: capture mem_read_val into the granted requester's rdata at this edge, then go to DONE.
  - Capture happens in cycle ACCESS + READ_LATENCY.
- DONE (1 cycle):
  - Granted requester's ack = 1, then go to IDLE.
  - The non-granted rdata is untouched. Writes never modify rdata.
- Latency, with req seen in IDLE at cycle 0:
  - Write: ACCESS at cycle 1, ack at cycle 2, IDLE at cycle 3.
  - Read: ACCESS at cycle 1, ack at cycle 2 + READ_LATENCY.
- Back-to-back: a req still high in the IDLE cycle after ack is treated as a new request. A requester must drop req in the cycle following ack to avoid a repeat.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- req dropped before ack is a protocol violation. The latched transaction still completes and ack still pulses; it is not cancelled.
- Requester fields changing during a transaction have no effect, because the values were latched in IDLE.
- mem_addr and mem_write_val hold their last latched value outside ACCESS.
- Reset asserted mid-transaction: next edge forces all reset values. No ack is issued; the in-flight transaction is dropped. A write is not issued if reset hits before ACCESS.
- Address and data pass through unmodified; no width arithmetic beyond the AW-bit address.

Decomposition:
- Shared package/header:
  - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3
  - requester indices REQ_CORE = 1'b0, REQ_HOST = 1'b1
- One natural sub-module: rr_pick2, a combinational winner select from (req0, req1, last_grant), producing valid and winner.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with m0_req = 1 → no mem strobes, no ack, busy = 0. Release reset → mem_write_en or mem_read_en in the first ACCESS cycle for requester 0.
- Write: m0 writes addr 8'h10, data 32'hDEADBEEF → mem_write_en = 1 for exactly cycle 1 with mem_addr = 8'h10 and mem_write_val = 32'hDEADBEEF; m0_ack = 1 at cycle 2; m0_rdata unchanged.
- Read latency: m1 reads addr 8'h20, memory model returns 32'h12345678.
  - READ_LATENCY = 1 → m1_ack at cycle 3 with m1_rdata = 32'h12345678.
  - READ_LATENCY = 3 → m1_ack at cycle 5.
- Contention: m0_req and m1_req both held high, each dropping for one cycle after its ack → grant sequence 0, 1, 0, 1; each requester gets 2 acks per 4 transactions; never two strobes in one cycle.
- Reset mid-op: assert reset in a WAIT cycle → next cycle state = IDLE, busy = 0, no ack ever pulses for that read, rdata = 0.
- Violation: m0_req dropped and m0_addr changed during ACCESS → memory still sees the originally latched address, and m0_ack still pulses.
